// File: rtl/mastermind_pkg.sv
// Shared Mastermind definitions: board geometry, colour codes and FSM state encoding.
// The VGA renderer imports these as well.
package mastermind_pkg;

    localparam int ROWS = 6;
    localparam int COLS = 4;
    localparam int CW   = 3;

    localparam int ROW_W = COLS * CW;
    localparam int FB_W  = 2 * CW;

    localparam logic [CW-1:0] EMPTY   = 3'd0;
    localparam logic [CW-1:0] BLUE    = 3'd1;
    localparam logic [CW-1:0] GREEN   = 3'd2;
    localparam logic [CW-1:0] CYAN    = 3'd3;
    localparam logic [CW-1:0] RED     = 3'd4;
    localparam logic [CW-1:0] YELLOW  = 3'd5;
    localparam logic [CW-1:0] MAGENTA = 3'd6;

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        INPUT = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_e;

    // The LFSR can emit 0 or 7, neither of which is a playable colour.
    function automatic logic [ROW_W-1:0] sanitize_code(input logic [ROW_W-1:0] code);
        logic [CW-1:0] d;
        sanitize_code = code;
        for (int c = 0; c < COLS; c++) begin
            d = code[c*CW +: CW];
            if (d == EMPTY)
                d = BLUE;
            else if (d == '1)
                d = MAGENTA;
            sanitize_code[c*CW +: CW] = d;
        end
    endfunction

endpackage

// File: rtl/mastermind_score.sv
// Combinational scorer: exact-position hits and colour-only hits of one guess row.
module mastermind_score
    import mastermind_pkg::*;
(
    input  logic [ROW_W-1:0] guess,
    input  logic [ROW_W-1:0] secret,
    output logic [2:0]       exact,
    output logic [2:0]       partial
);

    logic [2:0] cnt_g;
    logic [2:0] cnt_s;
    logic [2:0] common;

    // NOTE: every variable written here is defaulted first so no latch is inferred.
    always_comb begin
        exact  = '0;
        common = '0;
        cnt_g  = '0;
        cnt_s  = '0;
        for (int c = 0; c < COLS; c++) begin
            if (guess[c*CW +: CW] == secret[c*CW +: CW])
                exact = exact + 3'd1;
        end
        // Matches irrespective of position: sum of per-colour minimum counts.
        for (int k = 1; k <= 6; k++) begin
            cnt_g = '0;
            cnt_s = '0;
            for (int c = 0; c < COLS; c++) begin
                if (guess[c*CW +: CW] == 3'(k))
                    cnt_g = cnt_g + 3'd1;
                if (secret[c*CW +: CW] == 3'(k))
                    cnt_s = cnt_s + 3'd1;
            end
            common = common + ((cnt_g < cnt_s) ? cnt_g : cnt_s);
        end
        partial = common - exact;
    end

endmodule

// File: rtl/mastermind_game.sv
// Mastermind game engine: secret latch, guess entry from button pulses, row scoring,
// attempt tracking. All outputs come straight from flops.
module mastermind_game
    import mastermind_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [ROW_W-1:0]       secret_in,
    input  logic                   btn_left,
    input  logic                   btn_right,
    input  logic                   btn_color,
    input  logic                   btn_submit,
    output logic [ROWS*ROW_W-1:0]  matrix_flat,
    output logic [2:0]             guess_num,
    output logic [1:0]             cursor,
    output logic [ROWS*FB_W-1:0]   fb_flat,
    output logic                   q_Init,
    output logic                   q_Input,
    output logic                   q_Check,
    output logic                   q_Done,
    output logic                   win
);

    state_e                  state_q, state_d;
    logic [ROWS*ROW_W-1:0]   matrix_q, matrix_d;
    logic [ROWS*FB_W-1:0]    fb_q, fb_d;
    logic [2:0]              guess_num_q, guess_num_d;
    logic [1:0]              cursor_q, cursor_d;
    logic                    win_q, win_d;
    logic [ROW_W-1:0]        secret_q, secret_d;
    logic [3:0]              flags_q, flags_d;

    logic [ROW_W-1:0]        cur_row;
    logic [CW-1:0]           cur_slot;
    logic                    row_full;
    logic [2:0]              exact;
    logic [2:0]              partial;

    always_comb begin
        cur_row  = matrix_q[guess_num_q*ROW_W +: ROW_W];
        cur_slot = cur_row[cursor_q*CW +: CW];
        row_full = 1'b1;
        for (int c = 0; c < COLS; c++) begin
            if (cur_row[c*CW +: CW] == EMPTY)
                row_full = 1'b0;
        end
    end

    mastermind_score u_score (
        .guess   (cur_row),
        .secret  (secret_q),
        .exact   (exact),
        .partial (partial)
    );

    always_comb begin
        state_d     = state_q;
        matrix_d    = matrix_q;
        fb_d        = fb_q;
        guess_num_d = guess_num_q;
        cursor_d    = cursor_q;
        win_d       = win_q;
        secret_d    = secret_q;

        case (state_q)
            INIT, DONE: begin
                if (start) begin
                    secret_d    = sanitize_code(secret_in);
                    matrix_d    = '0;
                    fb_d        = '0;
                    guess_num_d = '0;
                    cursor_d    = '0;
                    win_d       = 1'b0;
                    state_d     = INPUT;
                end
            end
            INPUT: begin
                // A submit pulse masks the other buttons even when the row is incomplete.
                if (btn_submit) begin
                    if (row_full)
                        state_d = CHECK;
                end else if (btn_color) begin
                    matrix_d[guess_num_q*ROW_W + cursor_q*CW +: CW] =
                        (cur_slot == MAGENTA) ? BLUE : cur_slot + 3'd1;
                end else if (btn_left && !btn_right) begin
                    cursor_d = cursor_q - 2'd1;
                end else if (btn_right && !btn_left) begin
                    cursor_d = cursor_q + 2'd1;
                end
            end
            CHECK: begin
                fb_d[guess_num_q*FB_W +: FB_W] = {exact, partial};
                if (exact == 3'(COLS)) begin
                    win_d   = 1'b1;
                    state_d = DONE;
                end else if (guess_num_q == 3'(ROWS-1)) begin
                    win_d   = 1'b0;
                    state_d = DONE;
                end else begin
                    guess_num_d = guess_num_q + 3'd1;
                    cursor_d    = '0;
                    state_d     = INPUT;
                end
            end
            default: state_d = INIT;
        endcase

        flags_d = 4'b0001 << state_d;
    end

    // NOTE: sequential state uses non-blocking assignments only; the board is plain flops, so it is cleared by reset too.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= INIT;
            matrix_q    <= '0;
            fb_q        <= '0;
            guess_num_q <= '0;
            cursor_q    <= '0;
            win_q       <= 1'b0;
            secret_q    <= '0;
            flags_q     <= 4'b0001;
        end else begin
            state_q     <= state_d;
            matrix_q    <= matrix_d;
            fb_q        <= fb_d;
            guess_num_q <= guess_num_d;
            cursor_q    <= cursor_d;
            win_q       <= win_d;
            secret_q    <= secret_d;
            flags_q     <= flags_d;
        end
    end

    assign matrix_flat = matrix_q;
    assign fb_flat     = fb_q;
    assign guess_num   = guess_num_q;
    assign cursor      = cursor_q;
    assign win         = win_q;
    assign q_Init      = flags_q[0];
    assign q_Input     = flags_q[1];
    assign q_Check     = flags_q[2];
    assign q_Done      = flags_q[3];

endmodule

// File: tb/tb_mastermind_game.sv
// Directed bench for mastermind_game: a vector table for guess entry plus
// hand-written multi-cycle game sequences with hand-computed feedback.
module tb_mastermind_game;

    localparam logic [3:0] F_INIT  = 4'b0001;
    localparam logic [3:0] F_INPUT = 4'b0010;
    localparam logic [3:0] F_CHECK = 4'b0100;
    localparam logic [3:0] F_DONE  = 4'b1000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [11:0] secret_in = '0;
    logic        btn_left = 1'b0, btn_right = 1'b0, btn_color = 1'b0, btn_submit = 1'b0;
    logic [71:0] matrix_flat;
    logic [2:0]  guess_num;
    logic [1:0]  cursor;
    logic [35:0] fb_flat;
    logic        q_Init, q_Input, q_Check, q_Done, win;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mastermind_game dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .secret_in   (secret_in),
        .btn_left    (btn_left),
        .btn_right   (btn_right),
        .btn_color   (btn_color),
        .btn_submit  (btn_submit),
        .matrix_flat (matrix_flat),
        .guess_num   (guess_num),
        .cursor      (cursor),
        .fb_flat     (fb_flat),
        .q_Init      (q_Init),
        .q_Input     (q_Input),
        .q_Check     (q_Check),
        .q_Done      (q_Done),
        .win         (win)
    );

    typedef struct {
        logic        st;
        logic [11:0] sec;
        logic        sub, col, lft, rgt;
        logic [11:0] exp_row0;
        logic [1:0]  exp_cursor;
        logic [3:0]  exp_flags;
        logic [5:0]  exp_fb0;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] flags();
        return {q_Done, q_Check, q_Input, q_Init};
    endfunction

    // Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
    task automatic step(input logic st, input logic [11:0] sec,
                        input logic sub, input logic col, input logic lft, input logic rgt);
        @(negedge clk);
        start = st; secret_in = sec;
        btn_submit = sub; btn_color = col; btn_left = lft; btn_right = rgt;
        @(posedge clk);
        #1;
        start = 1'b0; btn_submit = 1'b0; btn_color = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
    endtask

    task automatic idle();
        step(1'b0, 12'o0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic start_game(input logic [11:0] sec);
        step(1'b1, sec, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Fills an empty row starting from cursor 0; four right moves bring the cursor back to 0.
    task automatic enter_row(input logic [11:0] g);
        logic [2:0] d;
        for (int c = 0; c < 4; c++) begin
            d = g[c*3 +: 3];
            for (int n = 0; n < int'(d); n++)
                step(1'b0, 12'o0, 1'b0, 1'b1, 1'b0, 1'b0);
            step(1'b0, 12'o0, 1'b0, 1'b0, 1'b0, 1'b1);
        end
    endtask

    task automatic submit_row();
        step(1'b0, 12'o0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle();
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_matrix"}, matrix_flat, 72'd0);
        check({tag, "_fb"}, {36'd0, fb_flat}, 72'd0);
        check({tag, "_guess_num"}, {69'd0, guess_num}, 72'd0);
        check({tag, "_cursor"}, {70'd0, cursor}, 72'd0);
        check({tag, "_win"}, {71'd0, win}, 72'd0);
    endtask

    initial begin
        logic [71:0] exp_matrix;
        logic [35:0] exp_fb;

        // st, sec, sub, col, lft, rgt, row0, cursor, flags, fb0
        vecs[0]  = '{1'b0, 12'o0, 1'b0, 1'b1, 1'b0, 1'b0, 12'o0001, 2'd0, F_INPUT, 6'o00};
        vecs[1]  = '{1'b0, 12'o0, 1'b0, 1'b1, 1'b0, 1'b0, 12'o0002, 2'd0, F_INPUT, 6'o00};
        vecs[2]  = '{1'b0, 12'o0, 1'b0, 1'b1, 1'b0, 1'b0, 12'o0003, 2'd0, F_INPUT, 6'o00};
        vecs[3]  = '{1'b0, 12'o0, 1'b0, 1'b1, 1'b0, 1'b0, 12'o0004, 2'd0, F_INPUT, 6'o00};
        vecs[4]  = '{1'b0, 12'o0, 1'b0, 1'b1, 1'b0, 1'b0, 12'o0005, 2'd0, F_INPUT, 6'o00};
        vecs[5]  = '{1'b0, 12'o0, 1'b0, 1'b1, 1'b0, 1'b0, 12'o0006, 2'd0, F_INPUT, 6'o00};
        vecs[6]  = '{1'b0, 12'o0, 1'b0, 1'b1, 1'b0, 1'b0, 12'o0001, 2'd0, F_INPUT, 6'o00};
        vecs[7]  = '{1'b0, 12'o0, 1'b0, 1'b0, 1'b1, 1'b0, 12'o0001, 2'd3, F_INPUT, 6'o00};
        vecs[8]  = '{1'b0, 12'o0, 1'b0, 1'b0, 1'b0, 1'b1, 12'o0001, 2'd0, F_INPUT, 6'o00};
        vecs[9]  = '{1'b0, 12'o0, 1'b0, 1'b0, 1'b1, 1'b1, 12'o0001, 2'd0, F_INPUT, 6'o00};
        vecs[10] = '{1'b0, 12'o0, 1'b0, 1'b0, 1'b0, 1'b1, 12'o0001, 2'd1, F_INPUT, 6'o00};
        vecs[11] = '{1'b0, 12'o0, 1'b0, 1'b1, 1'b0, 1'b0, 12'o0011, 2'd1, F_INPUT, 6'o00};
        vecs[12] = '{1'b0, 12'o0, 1'b1, 1'b0, 1'b0, 1'b0, 12'o0011, 2'd1, F_INPUT, 6'o00};
        vecs[13] = '{1'b1, 12'o5555, 1'b0, 1'b0, 1'b0, 1'b0, 12'o0011, 2'd1, F_INPUT, 6'o00};

        // Reset state
        do_reset();
        check_cleared("reset");
        check("reset_flags", {68'd0, flags()}, {68'd0, F_INIT});

        // Buttons in INIT are ignored
        step(1'b0, 12'o0, 1'b0, 1'b1, 1'b0, 1'b1);
        check("init_btn_ignored", matrix_flat, 72'd0);
        check("init_btn_flags", {68'd0, flags()}, {68'd0, F_INIT});

        // Test 1: exact guess wins on row 0
        start_game(12'o1234);
        check("t1_start_flags", {68'd0, flags()}, {68'd0, F_INPUT});
        enter_row(12'o1234);
        check("t1_row0", {60'd0, matrix_flat[11:0]}, {60'd0, 12'o1234});
        step(1'b0, 12'o0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("t1_check_flags", {68'd0, flags()}, {68'd0, F_CHECK});
        idle();
        check("t1_fb0", {66'd0, fb_flat[5:0]}, {66'd0, 6'o40});
        check("t1_win", {71'd0, win}, 72'd1);
        check("t1_done", {68'd0, flags()}, {68'd0, F_DONE});
        check("t1_guess_num", {69'd0, guess_num}, 72'd0);
        step(1'b0, 12'o0, 1'b1, 1'b1, 1'b1, 1'b0);
        check("t1_done_hold_matrix", {60'd0, matrix_flat[11:0]}, {60'd0, 12'o1234});
        check("t1_done_hold_flags", {68'd0, flags()}, {68'd0, F_DONE});

        // Test 2: restart from DONE, all colours misplaced
        start_game(12'o1234);
        check_cleared("t2_restart");
        check("t2_restart_flags", {68'd0, flags()}, {68'd0, F_INPUT});
        enter_row(12'o4321);
        submit_row();
        check("t2_fb0", {66'd0, fb_flat[5:0]}, {66'd0, 6'o04});
        check("t2_guess_num", {69'd0, guess_num}, 72'd1);
        check("t2_cursor", {70'd0, cursor}, 72'd0);
        check("t2_flags", {68'd0, flags()}, {68'd0, F_INPUT});

        // Test 3: repeated colours, then secret sanitising
        do_reset();
        start_game(12'o1122);
        enter_row(12'o1212);
        submit_row();
        check("t3_fb0_dup", {66'd0, fb_flat[5:0]}, {66'd0, 6'o22});
        do_reset();
        start_game(12'o0777);
        enter_row(12'o1666);
        submit_row();
        check("t3_sanitised_fb0", {66'd0, fb_flat[5:0]}, {66'd0, 6'o40});
        check("t3_sanitised_win", {71'd0, win}, 72'd1);

        // Test 4: table of single-cycle entry vectors on a fresh row
        do_reset();
        start_game(12'o1234);
        for (int i = 0; i < 14; i++) begin
            step(vecs[i].st, vecs[i].sec, vecs[i].sub, vecs[i].col, vecs[i].lft, vecs[i].rgt);
            check($sformatf("vec%0d_row0", i), {60'd0, matrix_flat[11:0]}, {60'd0, vecs[i].exp_row0});
            check($sformatf("vec%0d_cursor", i), {70'd0, cursor}, {70'd0, vecs[i].exp_cursor});
            check($sformatf("vec%0d_flags", i), {68'd0, flags()}, {68'd0, vecs[i].exp_flags});
            check($sformatf("vec%0d_fb0", i), {66'd0, fb_flat[5:0]}, {66'd0, vecs[i].exp_fb0});
        end

        // Test 5: six wrong guesses exhaust the board
        do_reset();
        start_game(12'o1234);
        exp_matrix = '0;
        exp_fb = '0;
        for (int r = 0; r < 6; r++) begin
            enter_row(12'o1235);
            submit_row();
            exp_matrix[r*12 +: 12] = 12'o1235;
            exp_fb[r*6 +: 6] = 6'o30;
            if (r < 5) begin
                check($sformatf("t5_row%0d_guess_num", r), {69'd0, guess_num}, 72'(r + 1));
                check($sformatf("t5_row%0d_flags", r), {68'd0, flags()}, {68'd0, F_INPUT});
            end
        end
        check("t5_matrix", matrix_flat, exp_matrix);
        check("t5_fb", {36'd0, fb_flat}, {36'd0, exp_fb});
        check("t5_done", {68'd0, flags()}, {68'd0, F_DONE});
        check("t5_lose", {71'd0, win}, 72'd0);
        check("t5_guess_num", {69'd0, guess_num}, 72'd5);
        start_game(12'o4444);
        check_cleared("t5_restart");
        check("t5_restart_flags", {68'd0, flags()}, {68'd0, F_INPUT});

        // Test 6: reset mid-CHECK and mid-row, then submit+color together
        start_game(12'o1234);
        enter_row(12'o4321);
        step(1'b0, 12'o0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("t6_in_check", {68'd0, flags()}, {68'd0, F_CHECK});
        do_reset();
        check_cleared("t6_reset_check");
        check("t6_reset_check_flags", {68'd0, flags()}, {68'd0, F_INIT});
        start_game(12'o1234);
        step(1'b0, 12'o0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 12'o0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 12'o0, 1'b0, 1'b1, 1'b0, 1'b0);
        do_reset();
        check_cleared("t6_reset_input");
        check("t6_reset_input_flags", {68'd0, flags()}, {68'd0, F_INIT});
        start_game(12'o1234);
        enter_row(12'o4321);
        step(1'b0, 12'o0, 1'b1, 1'b1, 1'b0, 1'b0);
        check("t6_sub_col_row0", {60'd0, matrix_flat[11:0]}, {60'd0, 12'o4321});
        check("t6_sub_col_flags", {68'd0, flags()}, {68'd0, F_CHECK});
        idle();
        check("t6_sub_col_fb0", {66'd0, fb_flat[5:0]}, {66'd0, 6'o04});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
